mux8x1_tdm: RTL and testbench
=============================

MUX8X1_TDM -- requirements
Module: mux8x1_tdm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Y, input, 8 bits: parallel word to be time-multiplexed onto D.
REQ-004 SHALL have port load, input, 1 bit: request to capture Y and start a frame.
REQ-005 SHALL have port D, output, 1 bit: serial data, equal to the captured bit selected by S.
REQ-006 SHALL have port S, output, 3 bits: current slot index, so that a downstream 1x8 demux rebuilds the word.
REQ-007 SHALL have port valid, output, 1 bit: D/S carry a data slot this cycle.
REQ-008 SHALL have port busy, output, 1 bit: frame in progress; load is ignored, except per REQ-015.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse on the last cycle of a frame.

Function
REQ-010 SHALL implement the FSM states IDLE and SHIFT, plus PARITY only when REQ-024 applies; all outputs are registered.
REQ-011 SHALL, in IDLE with load=1 at edge k, capture Y into an internal shadow register and enter SHIFT, with S=0 and valid=1 after edge k.
REQ-012 SHALL, in SHIFT, drive D = shadow[S] and increment S by 1 per cycle, giving exactly 8 valid cycles with S = 0..7 in order.
REQ-013 SHALL assert busy in every SHIFT/PARITY cycle and deassert it in IDLE.
REQ-014 SHALL, with PARITY absent, pulse done=1 together with S=7 and return to IDLE on the next edge unless REQ-015 applies.
REQ-015 SHALL, when load=1 in the last frame cycle, capture the new Y and restart at S=0 with no idle gap (back-to-back frames).
REQ-016 SHALL ignore load in any non-final SHIFT/PARITY cycle; changes on Y after capture SHALL NOT affect the frame in progress.
REQ-017 SHALL hold S at its last value and drive D=0 and valid=0 while in IDLE; S wrap 7->0 occurs only through REQ-015.

Reset
REQ-018 SHALL, on rst_n=0, immediately and asynchronously force state=IDLE, S=3'b000, D=0, valid=0, busy=0, done=0, shadow=8'h00.
REQ-019 SHALL abort a frame when reset is asserted mid-frame; no remaining slots are emitted and done does not pulse.
REQ-020 SHALL treat the first rising edge after rst_n deasserts as a normal IDLE cycle; load sampled on that edge is accepted.

Configuration
REQ-021 SHALL use the macro MUX8X1_TDM_PARITY_EN.
REQ-022 SHALL, when MUX8X1_TDM_PARITY_EN is undefined, have frames of 8 cycles and no PARITY state.
REQ-023 SHALL, when MUX8X1_TDM_PARITY_EN is defined, enter PARITY after S=7 for one cycle: D = XOR of the shadow bits (even parity), S=7, valid=0, busy=1, done=1.
REQ-024 SHALL, with parity defined, pulse done only in the PARITY cycle, which is the last cycle for REQ-015.

Verification
REQ-025 SHALL verify the basic frame: reset, then load=1 with Y=8'hA5 for one cycle -> next 8 cycles show S=0..7, D=1,0,1,0,0,1,0,1, valid=1, done on S=7.
REQ-026 SHALL verify load during busy: Y=8'h0F, then load=1 with Y=8'hFF at S=3 -> the frame still emits 1,1,1,1,0,0,0,0 and no second frame starts.
REQ-027 SHALL verify back-to-back frames: Y=8'h01 loaded, then load=1 with Y=8'h80 at S=7 -> the next cycle is S=0, D=0, valid=1, and the second frame ends with D=1 at S=7.
REQ-028 SHALL verify reset mid-frame: Y=8'hFF, rst_n=0 at S=4 -> all outputs 0 immediately, then IDLE, and done never pulses.
REQ-029 SHALL verify parity with MUX8X1_TDM_PARITY_EN defined: Y=8'h07 -> 8 data slots, then a PARITY cycle with D=1, valid=0, done=1; Y=8'h03 gives D=0.
REQ-030 SHALL verify round trip: D/S/valid driven into a 1x8 demux plus register across all 256 Y values -> the reconstructed word equals Y.

Source files
------------

// File: rtl/mux8x1_tdm.sv
// mux8x1_tdm: captures an 8-bit word and time-multiplexes it onto one serial
// line, one bit per cycle, with a slot index so a downstream 1x8 demux can rebuild it.
// Latency: slot 0 appears on the edge that samples load; a frame is 8 cycles,
// or 9 when MUX8X1_TDM_PARITY_EN is defined (adds a trailing even-parity cycle).
// Backpressure: none. load is honoured only in IDLE or in the last frame cycle;
// loading in the last cycle starts the next frame back-to-back.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   Y      - parallel word, captured into a shadow register on an accepted load
//   load   - capture request
//   D      - serial data: shadow[S] in data slots, parity bit in the parity cycle
//   S      - slot index 0..7; holds its last value while idle
//   valid  - D/S carry a data slot
//   busy   - frame in progress
//   done   - one-cycle pulse on the last cycle of a frame
module mux8x1_tdm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Y,
  input  logic       load,
  output logic       D,
  output logic [2:0] S,
  output logic       valid,
  output logic       busy,
  output logic       done
);

`ifdef MUX8X1_TDM_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] shadow, shadow_nxt;
  logic [2:0] s_nxt;
  logic [2:0] s_inc;
  logic       d_nxt, valid_nxt, busy_nxt, done_nxt;
  logic       last_cycle;
  logic       start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shadow <= 8'h00;
      S      <= 3'b000;
      D      <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      S      <= s_nxt;
      D      <= d_nxt;
      valid  <= valid_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  assign s_inc = S + 3'd1;

  // The final frame cycle is the only busy cycle in which load is accepted.
`ifdef MUX8X1_TDM_PARITY_EN
  assign last_cycle = (state == PARITY);
`else
  assign last_cycle = (state == SHIFT) && (S == 3'd7);
`endif

  assign start = load && ((state == IDLE) || last_cycle);

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    s_nxt      = S;
    d_nxt      = 1'b0;
    valid_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;

    if (start) begin
      // Slot 0 is driven straight from Y since shadow only updates on this edge.
      state_nxt  = SHIFT;
      shadow_nxt = Y;
      s_nxt      = 3'd0;
      d_nxt      = Y[0];
      valid_nxt  = 1'b1;
      busy_nxt   = 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (S != 3'd7) begin
            s_nxt     = s_inc;
            d_nxt     = shadow[s_inc];
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
`ifndef MUX8X1_TDM_PARITY_EN
            done_nxt  = (s_inc == 3'd7);
`endif
          end else begin
`ifdef MUX8X1_TDM_PARITY_EN
            state_nxt = PARITY;
            d_nxt     = ^shadow;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b1;
`else
            state_nxt = IDLE;
`endif
          end
        end
`ifdef MUX8X1_TDM_PARITY_EN
        PARITY: state_nxt = IDLE;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8x1_tdm.sv
// tb_mux8x1_tdm: directed bench for mux8x1_tdm covering reset, basic frame,
// load while busy, back-to-back frames, mid-frame reset, parity (when
// MUX8X1_TDM_PARITY_EN is defined) and a 256-word round trip through a demux.
module tb_mux8x1_tdm;

  logic       clk;
  logic       rst_n;
  logic [7:0] Y;
  logic       load;
  logic       D;
  logic [2:0] S;
  logic       valid;
  logic       busy;
  logic       done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0] rebuild;

  mux8x1_tdm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Y     (Y),
    .load  (load),
    .D     (D),
    .S     (S),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving side: 1x8 demux into a word register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rebuild <= 8'h00;
    else if (valid) rebuild[S] <= D;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic d, input logic [2:0] s,
                          input logic v, input logic b, input logic dn);
    chk({tag, ".D"},     {7'd0, D},     {7'd0, d});
    chk({tag, ".S"},     {5'd0, S},     {5'd0, s});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
    chk({tag, ".busy"},  {7'd0, busy},  {7'd0, b});
    chk({tag, ".done"},  {7'd0, done},  {7'd0, dn});
  endtask

  task automatic chk_slot(input string tag, input logic [7:0] y, input int i);
    logic dn;
`ifdef MUX8X1_TDM_PARITY_EN
    dn = 1'b0;
`else
    dn = (i == 7);
`endif
    chk_outs($sformatf("%s.slot%0d", tag, i), y[i], 3'(i), 1'b1, 1'b1, dn);
  endtask

  // Parity cycle after slot 7 when enabled; nothing otherwise.
  task automatic chk_tail(input string tag, input logic [7:0] y);
`ifdef MUX8X1_TDM_PARITY_EN
    tick();
    chk_outs({tag, ".parity"}, ^y, 3'd7, 1'b0, 1'b1, 1'b1);
`else
    if (y === 8'hxx) $display("unreachable %s", tag);
`endif
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] s);
    chk_outs({tag, ".idle"}, 1'b0, s, 1'b0, 1'b0, 1'b0);
  endtask

  // Data slots 1..7 of a frame whose slot 0 has just been checked.
  task automatic rest_of_frame(input string tag, input logic [7:0] y);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_slot(tag, y, i);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    Y     = 8'h00;
    load  = 1'b0;

    // Reset state, checked before any clock edge.
    #2;
    chk_outs("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    chk_idle("post_reset", 3'd0);

    // Basic frame 8'hA5; Y changes after capture must not matter.
    Y = 8'hA5; load = 1'b1;
    tick();
    load = 1'b0; Y = 8'h00;
    chk_slot("basic", 8'hA5, 0);
    rest_of_frame("basic", 8'hA5);
    chk_tail("basic", 8'hA5);
    tick();
    chk_idle("basic", 3'd7);

    // Load with 8'hFF while busy at S=3 is ignored.
    Y = 8'h0F; load = 1'b1;
    tick();
    load = 1'b0;
    chk_slot("busy_load", 8'h0F, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_slot("busy_load", 8'h0F, i);
      if (i == 3) begin load = 1'b1; Y = 8'hFF; end
      if (i == 4) load = 1'b0;
    end
    chk_tail("busy_load", 8'h0F);
    tick();
    chk_idle("busy_load", 3'd7);
    tick();
    chk_idle("busy_load2", 3'd7);

    // Back-to-back frames: 8'h01 then 8'h80 loaded in the last cycle.
    Y = 8'h01; load = 1'b1;
    tick();
    load = 1'b0;
    chk_slot("b2b_a", 8'h01, 0);
    rest_of_frame("b2b_a", 8'h01);
    chk_tail("b2b_a", 8'h01);
    Y = 8'h80; load = 1'b1;
    tick();
    load = 1'b0;
    chk_slot("b2b_b", 8'h80, 0);
    rest_of_frame("b2b_b", 8'h80);
    chk_tail("b2b_b", 8'h80);
    tick();
    chk_idle("b2b", 3'd7);

    // Reset asserted mid-frame at S=4.
    Y = 8'hFF; load = 1'b1;
    tick();
    load = 1'b0;
    chk_slot("midrst", 8'hFF, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_slot("midrst", 8'hFF, i);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_outs("midrst.async", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_outs("midrst.held", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk_idle("midrst.after1", 3'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_idle("midrst.after", 3'd0);
    end

    // Load sampled on the first edge after reset release is accepted.
    #2 rst_n = 1'b0;
    #2 Y = 8'h07; load = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    load = 1'b0;
    chk_slot("first_edge", 8'h07, 0);
    rest_of_frame("first_edge", 8'h07);
    chk_tail("first_edge", 8'h07);
    tick();
    chk_idle("first_edge", 3'd7);

    // Even-parity word 8'h03 (parity bit 0 when enabled).
    Y = 8'h03; load = 1'b1;
    tick();
    load = 1'b0;
    chk_slot("par03", 8'h03, 0);
    rest_of_frame("par03", 8'h03);
    chk_tail("par03", 8'h03);
    tick();
    chk_idle("par03", 3'd7);

    // Round trip through the demux for every word.
    for (int v = 0; v < 256; v++) begin
      Y = 8'(v); load = 1'b1;
      tick();
      load = 1'b0;
      repeat (7) tick();
`ifdef MUX8X1_TDM_PARITY_EN
      tick();
`endif
      tick();
      chk($sformatf("roundtrip_%0d", v), rebuild, 8'(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
